uart_tx_scheduler: RTL

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

---
 rtl/uart_tx_scheduler.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_scheduler.sv
// Two-requester byte scheduler for a memory-mapped uart: INIT writes CLK_DIV, then each byte polls STATUS and writes DATA.
// Define UART_TX_SCHEDULER_RR_EN for round-robin arbitration; the default build uses fixed priority (requester 0 wins).
module uart_tx_scheduler #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter logic [15:0] CLK_DIV_INIT = 16'd103
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [7:0]  req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_data,
    output logic        req1_ready,
    output logic [31:0] address_out,
    output logic        sel_out,
    output logic        read_out,
    output logic [3:0]  write_mask_out,
    output logic [31:0] write_value_out,
    input  logic [31:0] read_value_in,
    input  logic        ready_in,
    output logic        busy,
    output logic        grant_id
);

    // state    | meaning
    // ST_INIT  | writing CLK_DIV_INIT to the CLK_DIV register
    // ST_ARB   | idle, bus quiet, granting the next requester
    // ST_POLL  | reading STATUS until bit 0 reports the transmitter free
    // ST_WRITE | writing the latched byte to DATA
    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_ARB   = 2'd1,
        ST_POLL  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  data_q, data_d;
    logic        grant_q, grant_d;
    logic        sel_q, sel_d;
    logic        read_q, read_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  mask_q, mask_d;
    logic [31:0] value_q, value_d;

    logic any_valid;
    logic win1;
    logic in_arb;
    logic xfer;
    logic unused_status;

    assign unused_status = ^read_value_in[31:1];
    assign any_valid     = req0_valid | req1_valid;
    assign in_arb        = (state_q == ST_ARB);
    // A completion only counts while a request is actually on the bus.
    assign xfer          = sel_q & ready_in;

`ifdef UART_TX_SCHEDULER_RR_EN
    logic rr_q, rr_d;

    assign win1 = req1_valid & (~req0_valid | rr_q);

    always_comb begin
        rr_d = rr_q;
        if (in_arb && any_valid) begin
            rr_d = ~win1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    assign win1 = req1_valid & ~req0_valid;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_INIT;
            data_q  <= 8'd0;
            grant_q <= 1'b0;
            sel_q   <= 1'b0;
            read_q  <= 1'b0;
            addr_q  <= 32'd0;
            mask_q  <= 4'd0;
            value_q <= 32'd0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            read_q  <= read_d;
            addr_q  <= addr_d;
            mask_q  <= mask_d;
            value_q <= value_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        grant_d = grant_q;
        case (state_q)
            ST_INIT: begin
                if (xfer) state_d = ST_ARB;
            end
            ST_ARB: begin
                if (any_valid) begin
                    state_d = ST_POLL;
                    data_d  = win1 ? req1_data : req0_data;
                    grant_d = win1;
                end
            end
            ST_POLL: begin
                if (xfer && read_value_in[0]) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (xfer) begin
                    state_d = ST_ARB;
                    grant_d = 1'b0;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Bus outputs are registered from the next state so they line up with state_q
    // and are cleared asynchronously by reset.
    always_comb begin
        sel_d   = 1'b0;
        read_d  = 1'b0;
        addr_d  = 32'd0;
        mask_d  = 4'd0;
        value_d = 32'd0;
        case (state_d)
            ST_INIT: begin
                sel_d   = 1'b1;
                addr_d  = BASE_ADDR;
                mask_d  = 4'b0011;
                value_d = {16'd0, CLK_DIV_INIT};
            end
            ST_POLL: begin
                sel_d  = 1'b1;
                read_d = 1'b1;
                addr_d = BASE_ADDR + 32'd4;
            end
            ST_WRITE: begin
                sel_d   = 1'b1;
                addr_d  = BASE_ADDR + 32'd8;
                mask_d  = 4'b0001;
                value_d = {24'd0, data_d};
            end
            default: ;
        endcase
    end

    assign req0_ready      = in_arb & req0_valid & ~win1;
    assign req1_ready      = in_arb & win1;
    assign busy            = ~in_arb;
    assign grant_id        = grant_q;
    assign sel_out         = sel_q;
    assign read_out        = read_q;
    assign address_out     = addr_q;
    assign write_mask_out  = mask_q;
    assign write_value_out = value_q;

endmodule
